rggen_apb_initiator: RTL and testbench

RGGEN_APB_INITIATOR -- requirements
Module: rggen_apb_initiator

---
 rtl/rggen_apb_initiator.sv | 116 +++++++++++
 tb/tb_rggen_apb_initiator.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rggen_apb_initiator.sv
// rggen_apb_initiator: bridges a simple valid/ready register bus onto an APB
// completer. Single outstanding transfer, fully registered outputs, and an
// optional ACCESS-phase timeout so a dead completer cannot hang the bus.
module rggen_apb_initiator #(
   parameter int         ADDRESS_WIDTH  = 8,
   parameter int         BUS_WIDTH      = 32,
   parameter logic [2:0] PPROT          = 3'b000,
   parameter int         TIMEOUT_CYCLES = 0
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_bus_valid,
   input  logic [1:0]               i_bus_access,
   input  logic [ADDRESS_WIDTH-1:0] i_bus_address,
   input  logic [BUS_WIDTH-1:0]     i_bus_write_data,
   input  logic [BUS_WIDTH/8-1:0]   i_bus_strobe,
   output logic                     o_bus_ready,
   output logic [1:0]               o_bus_status,
   output logic [BUS_WIDTH-1:0]     o_bus_read_data,
   output logic                     o_psel,
   output logic                     o_penable,
   output logic                     o_pwrite,
   output logic [ADDRESS_WIDTH-1:0] o_paddr,
   output logic [2:0]               o_pprot,
   output logic [BUS_WIDTH/8-1:0]   o_pstrb,
   output logic [BUS_WIDTH-1:0]     o_pwdata,
   input  logic                     i_pready,
   input  logic [BUS_WIDTH-1:0]     i_prdata,
   input  logic                     i_pslverr
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   localparam logic [15:0] TIMEOUT_LAST =
      (TIMEOUT_CYCLES > 0) ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

   state_t      state;
   logic [15:0] wait_cnt;
   logic        timeout_hit;
   logic        unused_access_bit;

   // Access type bit 1 carries no meaning for APB; only bit 0 selects write.
   assign unused_access_bit = i_bus_access[1];

   assign o_pprot = PPROT;

   // Asserted on the Nth consecutive not-ready ACCESS cycle (never when disabled).
   assign timeout_hit = (TIMEOUT_CYCLES > 0) && (wait_cnt == TIMEOUT_LAST);

   // Transfer sequencer: every bus and APB output is a register updated here.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state           <= IDLE;
         wait_cnt        <= '0;
         o_psel          <= 1'b0;
         o_penable       <= 1'b0;
         o_pwrite        <= 1'b0;
         o_paddr         <= '0;
         o_pstrb         <= '0;
         o_pwdata        <= '0;
         o_bus_ready     <= 1'b0;
         o_bus_status    <= 2'b00;
         o_bus_read_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_bus_valid) begin
                  // Request is captured once; later input changes are ignored.
                  state    <= SETUP;
                  wait_cnt <= '0;
                  o_psel   <= 1'b1;
                  o_pwrite <= i_bus_access[0];
                  o_paddr  <= i_bus_address;
                  o_pstrb  <= i_bus_access[0] ? i_bus_strobe : '0;
                  o_pwdata <= i_bus_write_data;
               end
            end
            SETUP: begin
               state     <= ACCESS;
               o_penable <= 1'b1;
            end
            ACCESS: begin
               if (i_pready) begin
                  // Completion wins over a timeout landing on the same cycle.
                  state           <= RESP;
                  o_psel          <= 1'b0;
                  o_penable       <= 1'b0;
                  o_bus_ready     <= 1'b1;
                  o_bus_status    <= i_pslverr ? 2'b10 : 2'b00;
                  o_bus_read_data <= o_pwrite ? '0 : i_prdata;
               end else if (timeout_hit) begin
                  state           <= RESP;
                  o_psel          <= 1'b0;
                  o_penable       <= 1'b0;
                  o_bus_ready     <= 1'b1;
                  o_bus_status    <= 2'b11;
                  o_bus_read_data <= '0;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
            RESP: begin
               state       <= IDLE;
               o_bus_ready <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rggen_apb_initiator.sv
// tb_rggen_apb_initiator: randomized scoreboard bench. A driver issues bus
// requests, an APB completer model inserts wait states/errors, and a monitor
// checks each completion against a transaction-level reference model.
module tb_rggen_apb_initiator;

   localparam int TO = 5;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_bus_valid = 1'b0;
   logic [1:0]  i_bus_access = '0;
   logic [7:0]  i_bus_address = '0;
   logic [31:0] i_bus_write_data = '0;
   logic [3:0]  i_bus_strobe = '0;
   logic        o_bus_ready;
   logic [1:0]  o_bus_status;
   logic [31:0] o_bus_read_data;
   logic        o_psel, o_penable, o_pwrite;
   logic [7:0]  o_paddr;
   logic [2:0]  o_pprot;
   logic [3:0]  o_pstrb;
   logic [31:0] o_pwdata;
   logic        i_pready = 1'b0;
   logic [31:0] i_prdata = '0;
   logic        i_pslverr = 1'b0;

   rggen_apb_initiator #(
      .ADDRESS_WIDTH(8), .BUS_WIDTH(32), .PPROT(3'b000), .TIMEOUT_CYCLES(TO)
   ) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_bus_valid(i_bus_valid), .i_bus_access(i_bus_access),
      .i_bus_address(i_bus_address), .i_bus_write_data(i_bus_write_data),
      .i_bus_strobe(i_bus_strobe), .o_bus_ready(o_bus_ready),
      .o_bus_status(o_bus_status), .o_bus_read_data(o_bus_read_data),
      .o_psel(o_psel), .o_penable(o_penable), .o_pwrite(o_pwrite),
      .o_paddr(o_paddr), .o_pprot(o_pprot), .o_pstrb(o_pstrb),
      .o_pwdata(o_pwdata), .i_pready(i_pready), .i_prdata(i_prdata),
      .i_pslverr(i_pslverr)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      bit          wr;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int          waits;      // not-ready ACCESS cycles before ready
      logic [31:0] rdata;
      bit          err;        // pslverr at the ready cycle
      bit          err_early;  // pslverr during wait cycles (must be ignored)
   } txn_t;

   typedef struct {
      logic [1:0]  status;
      logic [31:0] rdata;
      int          acc;        // ACCESS cycles the transfer should take
   } exp_t;

   txn_t slv_q[$];
   exp_t exp_q[$];
   int   checks = 0;
   int   passed = 0;
   int   acc_n  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference model: outcome of a transfer from its wait count and response.
   function automatic exp_t model(input txn_t t);
      exp_t e;
      if (t.waits >= TO) begin
         e.status = 2'b11; e.rdata = '0; e.acc = TO;
      end else begin
         e.status = t.err ? 2'b10 : 2'b00;
         e.rdata  = t.wr ? 32'h0 : t.rdata;
         e.acc    = t.waits + 1;
      end
      return e;
   endfunction

   function automatic txn_t mk(input bit wr, input logic [7:0] a, input logic [31:0] wd,
                               input logic [3:0] s, input int w, input logic [31:0] rd,
                               input bit err, input bit ee);
      txn_t t;
      t.wr = wr; t.addr = a; t.wdata = wd; t.strb = s; t.waits = w;
      t.rdata = rd; t.err = err; t.err_early = ee;
      return t;
   endfunction

   function automatic txn_t rnd_txn();
      return mk(1'($urandom), 8'($urandom), $urandom, 4'($urandom),
                int'($urandom_range(0, 7)), $urandom,
                ($urandom_range(0, 3) == 0), 1'($urandom));
   endfunction

   // APB completer model plus per-cycle field checks during SETUP/ACCESS.
   initial begin
      txn_t cur;
      cur = mk(0, 0, 0, 0, 0, 0, 0, 0);
      forever begin
         @(negedge i_clk);
         if (o_psel) begin
            if (!o_penable) begin
               if (slv_q.size() == 0) chk("setup_without_request", 1, 0);
               else cur = slv_q.pop_front();
               acc_n = 0;
            end else begin
               acc_n++;
            end
            chk("paddr", o_paddr, cur.addr);
            chk("pwrite", o_pwrite, cur.wr);
            chk("pstrb", o_pstrb, cur.wr ? cur.strb : 4'h0);
            chk("pwdata", o_pwdata, cur.wdata);
            if (o_penable && acc_n == cur.waits + 1) begin
               i_pready = 1'b1; i_prdata = cur.rdata; i_pslverr = cur.err;
            end else if (o_penable) begin
               i_pready = 1'b0; i_prdata = $urandom; i_pslverr = cur.err_early;
            end else begin
               i_pready = 1'($urandom); i_prdata = $urandom; i_pslverr = 1'($urandom);
            end
         end else begin
            i_pready = 1'($urandom); i_prdata = $urandom; i_pslverr = 1'($urandom);
         end
      end
   end

   // Completion monitor: pops the scoreboard whenever o_bus_ready is seen.
   initial begin
      exp_t e;
      forever begin
         @(negedge i_clk);
         if (o_bus_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_ready", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("status", o_bus_status, e.status);
               chk("read_data", o_bus_read_data, e.rdata);
               chk("access_cycles", acc_n, e.acc);
               chk("psel_penable_in_resp", {o_psel, o_penable}, 2'b00);
            end
         end
      end
   end

   task automatic issue(input txn_t t);
      exp_t e;
      int   n;
      e = model(t);
      n = 0;
      slv_q.push_back(t);
      exp_q.push_back(e);
      i_bus_valid      = 1'b1;
      i_bus_access     = {1'($urandom), t.wr};
      i_bus_address    = t.addr;
      i_bus_write_data = t.wdata;
      i_bus_strobe     = t.strb;
      do begin
         @(posedge i_clk); #1;
         n++;
         // Request fields change after capture; the DUT must ignore them.
         i_bus_access     = 2'($urandom);
         i_bus_address    = 8'($urandom);
         i_bus_write_data = $urandom;
         i_bus_strobe     = 4'($urandom);
      end while (!o_bus_ready && n < 100);
      chk("latency", n, 2 + e.acc);
      @(posedge i_clk); #1;
      i_bus_valid = 1'b0;
      chk("idle_after_resp", {o_psel, o_penable, o_bus_ready}, 3'b000);
   endtask

   // Kill a transfer with reset while it sits in ACCESS.
   task automatic reset_mid_access();
      txn_t t;
      t = mk(0, 8'h5A, 32'hCAFE0001, 4'hF, 20, 32'h0, 0, 0);
      slv_q.push_back(t);
      i_bus_valid = 1'b1; i_bus_access = 2'b00; i_bus_address = t.addr;
      i_bus_write_data = t.wdata; i_bus_strobe = t.strb;
      repeat (3) begin @(posedge i_clk); #1; end
      chk("in_access_before_reset", {o_psel, o_penable}, 2'b11);
      i_rst = 1'b1;
      #1;
      chk("rst_psel_penable", {o_psel, o_penable}, 2'b00);
      chk("rst_ready_paddr", {o_bus_ready, o_paddr}, 9'h0);
      chk("rst_pwdata", o_pwdata, 32'h0);
      i_bus_valid = 1'b0;
      repeat (2) @(posedge i_clk);
      #1 i_rst = 1'b0;
      repeat (4) @(posedge i_clk);
      #1;
   endtask

   initial begin
      #(200000);
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(posedge i_clk);
      #1;
      chk("reset_ctrl", {o_psel, o_penable, o_pwrite, o_bus_ready}, 4'b0000);
      chk("reset_paddr_pstrb", {o_paddr, o_pstrb}, 12'h0);
      chk("reset_pwdata", o_pwdata, 32'h0);
      chk("reset_rdata_status", {o_bus_read_data, o_bus_status}, 34'h0);
      chk("pprot", o_pprot, 3'b000);
      i_rst = 1'b0;
      @(posedge i_clk); #1;

      // Directed cases.
      issue(mk(1, 8'h10, 32'hDEADBEEF, 4'b0011, 0, 32'h0, 0, 0));
      issue(mk(0, 8'h24, 32'h0, 4'hF, 3, 32'h12345678, 0, 0));
      issue(mk(0, 8'h30, 32'h0, 4'hF, 2, 32'hA5A5A5A5, 1, 1));
      issue(mk(0, 8'h40, 32'h0, 4'hF, 20, 32'h11112222, 0, 1));
      issue(mk(0, 8'h44, 32'h0, 4'hF, 4, 32'h33334444, 0, 0));
      reset_mid_access();
      issue(mk(1, 8'h50, 32'h01020304, 4'b1100, 1, 32'h0, 0, 0));
      // Back-to-back write then read.
      issue(mk(1, 8'h60, 32'hFEEDFACE, 4'b0101, 0, 32'h0, 0, 0));
      issue(mk(0, 8'h64, 32'h0, 4'hF, 1, 32'h87654321, 0, 0));

      // Randomized traffic with occasional idle gaps.
      for (int i = 0; i < 60; i++) begin
         issue(rnd_txn());
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge i_clk);
         #1;
      end

      repeat (3) @(posedge i_clk);
      #1;
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
